// File: rtl/complex_serializer_pkg.sv
// complex_serializer_pkg
//   Shared types and constants for the complex-word serializer:
//   FSM state encoding, per-word mode codes and small mode helpers.
package complex_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2
   } state_t;

   localparam logic [1:0] MODE_RI = 2'b00;   // real then imag
   localparam logic [1:0] MODE_R  = 2'b01;   // real only
   localparam logic [1:0] MODE_I  = 2'b10;   // imag only
   localparam logic [1:0] MODE_IR = 2'b11;   // imag then real

   // Modes that emit both halves take two output beats per word.
   function automatic logic mode_two_half(input logic [1:0] mode);
      return (mode == MODE_RI) || (mode == MODE_IR);
   endfunction

   // The first emitted half is imag exactly when the upper mode bit is set.
   function automatic logic mode_first_imag(input logic [1:0] mode);
      return mode[1];
   endfunction

endpackage

// File: rtl/complex_serializer_if.sv
// complex_serializer_if
//   Bundles the producer-side (word in) and consumer-side (half-word out)
//   handshakes plus the completed-word counter.
//   slave  : serializer view (consumes RIword_i/mode_i/valid_i/ready_i)
//   master : environment view (drives the inputs, observes the outputs)
interface complex_serializer_if #(
   parameter int WIDTH_IN_WORD = 32,
   parameter int CNT_WIDTH     = 16
);
   localparam int H = WIDTH_IN_WORD / 2;

   logic [WIDTH_IN_WORD-1:0] RIword_i;
   logic [1:0]               mode_i;
   logic                     valid_i;
   logic                     ready_o;
   logic [H-1:0]             data_o;
   logic                     isImag_o;
   logic                     last_o;
   logic                     valid_o;
   logic                     ready_i;
   logic [CNT_WIDTH-1:0]     cnt_o;

   modport slave (
      input  RIword_i, mode_i, valid_i, ready_i,
      output ready_o, data_o, isImag_o, last_o, valid_o, cnt_o
   );

   modport master (
      output RIword_i, mode_i, valid_i, ready_i,
      input  ready_o, data_o, isImag_o, last_o, valid_o, cnt_o
   );

endinterface

// File: rtl/complex_word_buffer.sv
// complex_word_buffer
//   Holding register for one packed complex word and its mode, plus the
//   real/imag split and first/second half selection.
//   clk_i, rst_i : clock, async active-high reset (register cleared to 0)
//   load         : capture word/mode
//   word, mode   : incoming packed word {real, imag} and its mode
//   phase        : 0 = first half of the word, 1 = second half
//   data         : selected half-word
//   isImag       : 1 when data is the imag half
//   mode_held    : mode of the word currently held
module complex_word_buffer
   import complex_serializer_pkg::*;
#(
   parameter int WIDTH_IN_WORD = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       load,
   input  logic [WIDTH_IN_WORD-1:0]   word,
   input  logic [1:0]                 mode,
   input  logic                       phase,
   output logic [WIDTH_IN_WORD/2-1:0] data,
   output logic                       isImag,
   output logic [1:0]                 mode_held
);
   localparam int H = WIDTH_IN_WORD / 2;

   logic [WIDTH_IN_WORD-1:0] word_q;
   logic [1:0]               mode_q;
   logic                     sel_imag;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         mode_q <= MODE_RI;
      end else if (load) begin
         word_q <= word;
         mode_q <= mode;
      end
   end

   // Second half is always the opposite component of the first.
   assign sel_imag  = mode_first_imag(mode_q) ^ phase;
   assign data      = sel_imag ? word_q[H-1:0] : word_q[WIDTH_IN_WORD-1:H];
   assign isImag    = sel_imag;
   assign mode_held = mode_q;

endmodule

// File: rtl/complex_serializer.sv
// complex_serializer
//   Time-multiplexes packed complex words {real, imag} onto a half-width
//   stream. Per-word mode picks which halves go out and in what order;
//   cnt_o counts completed words and wraps.
//   clk_i : clock
//   rst_i : async active-high reset
//   bus   : complex_serializer_if.slave (input word handshake, output
//           half-word handshake, completed-word counter)
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | no word held, ready for input, valid_o low
//   ST_FIRST  | presenting first half of the held word
//   ST_SECOND | presenting second half (two-half modes only), last_o=1
module complex_serializer
   import complex_serializer_pkg::*;
#(
   parameter int WIDTH_IN_WORD = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   complex_serializer_if.slave bus
);
   localparam int H = WIDTH_IN_WORD / 2;

   state_t               state_q;
   state_t               state_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [1:0]           mode_held;
   logic [H-1:0]         buf_data;
   logic                 buf_is_imag;
   logic                 valid_int;
   logic                 last_int;
   logic                 complete;
   logic                 ready_int;
   logic                 load;
   logic                 phase;

   assign valid_int = (state_q != ST_IDLE);
   assign phase     = (state_q == ST_SECOND);
   assign last_int  = ((state_q == ST_FIRST) && !mode_two_half(mode_held)) ||
                      (state_q == ST_SECOND);
   assign complete  = valid_int & bus.ready_i & last_int;
   // Held low during reset so nothing is accepted while the block is cleared.
   assign ready_int = !rst_i && ((state_q == ST_IDLE) || complete);
   assign load      = bus.valid_i & ready_int;

   complex_word_buffer #(
      .WIDTH_IN_WORD (WIDTH_IN_WORD)
   ) u_buffer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (load),
      .word      (bus.RIword_i),
      .mode      (bus.mode_i),
      .phase     (phase),
      .data      (buf_data),
      .isImag    (buf_is_imag),
      .mode_held (mode_held)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.valid_i) begin
               state_d = ST_FIRST;
            end
         end
         ST_FIRST: begin
            if (bus.ready_i) begin
               if (mode_two_half(mode_held)) begin
                  state_d = ST_SECOND;
               end else if (bus.valid_i) begin
                  state_d = ST_FIRST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_SECOND: begin
            if (bus.ready_i) begin
               state_d = bus.valid_i ? ST_FIRST : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (complete) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.ready_o  = ready_int;
   assign bus.valid_o  = valid_int;
   assign bus.data_o   = buf_data;
   assign bus.isImag_o = buf_is_imag;
   assign bus.last_o   = last_int;
   assign bus.cnt_o    = cnt_q;

endmodule
